// File: rtl/vx_om_ds_occlusion.sv
// vx_om_ds_occlusion: two-stage depth/stencil test with lane mask, depth bounds and occlusion query counter.
// The package carries the shared register layout and the OM compare/stencil-op encodings.
package vx_om_ds_pkg;

    localparam int OM_STENCIL_BITS = 8;

    localparam logic [2:0] OM_CMP_NEVER    = 3'd0;
    localparam logic [2:0] OM_CMP_LESS     = 3'd1;
    localparam logic [2:0] OM_CMP_EQUAL    = 3'd2;
    localparam logic [2:0] OM_CMP_LEQUAL   = 3'd3;
    localparam logic [2:0] OM_CMP_GREATER  = 3'd4;
    localparam logic [2:0] OM_CMP_NOTEQUAL = 3'd5;
    localparam logic [2:0] OM_CMP_GEQUAL   = 3'd6;
    localparam logic [2:0] OM_CMP_ALWAYS   = 3'd7;

    localparam logic [2:0] OM_OP_KEEP      = 3'd0;
    localparam logic [2:0] OM_OP_ZERO      = 3'd1;
    localparam logic [2:0] OM_OP_REPLACE   = 3'd2;
    localparam logic [2:0] OM_OP_INCR      = 3'd3;
    localparam logic [2:0] OM_OP_DECR      = 3'd4;
    localparam logic [2:0] OM_OP_INVERT    = 3'd5;
    localparam logic [2:0] OM_OP_INCR_WRAP = 3'd6;
    localparam logic [2:0] OM_OP_DECR_WRAP = 3'd7;

    // Per-face fields are indexed by face: [0] = front, [1] = back.
    typedef struct packed {
        logic [2:0]                            depth_func;
        logic                                  depth_writemask;
        logic [1:0][2:0]                       stencil_func;
        logic [1:0][2:0]                       stencil_zpass;
        logic [1:0][2:0]                       stencil_zfail;
        logic [1:0][2:0]                       stencil_fail;
        logic [1:0][OM_STENCIL_BITS-1:0]       stencil_ref;
        logic [1:0][OM_STENCIL_BITS-1:0]       stencil_mask;
        logic [1:0][OM_STENCIL_BITS-1:0]       stencil_writemask;
    } om_dcrs_t;

endpackage

module vx_om_ds_occlusion
    import vx_om_ds_pkg::*;
#(
    parameter string INSTANCE_ID  = "",
    parameter int    NUM_LANES    = 4,
    parameter int    TAG_WIDTH    = 1,
    parameter int    DEPTH_BITS   = 24,
    parameter int    STENCIL_BITS = 8,
    parameter int    COUNT_BITS   = 32
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  om_dcrs_t                                 i_dcrs,
    input  logic                                     i_bounds_en,
    input  logic [DEPTH_BITS-1:0]                    i_bounds_min,
    input  logic [DEPTH_BITS-1:0]                    i_bounds_max,
    input  logic                                     i_valid_in,
    output logic                                     o_ready_in,
    input  logic [TAG_WIDTH-1:0]                     i_tag_in,
    input  logic [NUM_LANES-1:0]                     i_mask_in,
    input  logic [NUM_LANES-1:0]                     i_face,
    input  logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     i_depth_ref,
    input  logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     i_depth_val,
    input  logic [NUM_LANES-1:0][STENCIL_BITS-1:0]   i_stencil_val,
    output logic                                     o_valid_out,
    input  logic                                     i_ready_out,
    output logic [TAG_WIDTH-1:0]                     o_tag_out,
    output logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     o_depth_out,
    output logic [NUM_LANES-1:0][STENCIL_BITS-1:0]   o_stencil_out,
    output logic [NUM_LANES-1:0]                     o_pass_out,
    input  logic                                     i_query_begin,
    input  logic                                     i_query_end,
    output logic                                     o_query_active,
    output logic                                     o_query_done,
    output logic [COUNT_BITS-1:0]                    o_query_count
);

    localparam int PW = $clog2(NUM_LANES + 1);
    localparam int CW = (DEPTH_BITS > STENCIL_BITS) ? DEPTH_BITS : STENCIL_BITS;

    // Encoding bits 0/1/2 select less/equal/greater, so NEVER and ALWAYS fall out naturally.
    function automatic logic f_cmp(input logic [2:0] func, input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (func[0] & (a < b)) | (func[1] & (a == b)) | (func[2] & (a > b));
    endfunction

    function automatic logic [STENCIL_BITS-1:0] f_op(input logic [2:0] op, input logic [STENCIL_BITS-1:0] val,
                                                     input logic [STENCIL_BITS-1:0] sref);
        logic [STENCIL_BITS-1:0] res;
        case (op)
            OM_OP_ZERO:      res = '0;
            OM_OP_REPLACE:   res = sref;
            OM_OP_INCR:      res = (&val) ? val : val + STENCIL_BITS'(1);
            OM_OP_DECR:      res = (val == '0) ? val : val - STENCIL_BITS'(1);
            OM_OP_INVERT:    res = ~val;
            OM_OP_INCR_WRAP: res = val + STENCIL_BITS'(1);
            OM_OP_DECR_WRAP: res = val - STENCIL_BITS'(1);
            default:         res = val;
        endcase
        return res;
    endfunction

    logic                                     r_active, r_epoch;
    logic [COUNT_BITS-1:0]                    r_count;
    logic                                     r_s1_valid, r_s1_flag, r_s1_epoch;
    logic [TAG_WIDTH-1:0]                     r_s1_tag;
    logic [NUM_LANES-1:0]                     r_s1_mask, r_s1_face, r_s1_dpass, r_s1_spass;
    logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     r_s1_dref, r_s1_dval;
    logic [NUM_LANES-1:0][STENCIL_BITS-1:0]   r_s1_sval;
    logic                                     r_s2_valid, r_s2_flag, r_s2_epoch;
    logic [TAG_WIDTH-1:0]                     r_s2_tag;
    logic [NUM_LANES-1:0]                     r_s2_pass;
    logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     r_s2_depth;
    logic [NUM_LANES-1:0][STENCIL_BITS-1:0]   r_s2_sten;

    logic                                     w_stall, w_fire, w_count_en;
    logic [NUM_LANES-1:0]                     w_dpass, w_spass, w_pass;
    logic [NUM_LANES-1:0][2:0]                w_op;
    logic [NUM_LANES-1:0][STENCIL_BITS-1:0]   w_sref, w_smask, w_wm, w_sres, w_sten;
    logic [NUM_LANES-1:0][DEPTH_BITS-1:0]     w_depth;
    logic [PW-1:0]                            w_pop;
    logic [COUNT_BITS:0]                      w_sum;

    assign w_stall    = r_s2_valid & ~i_ready_out;
    assign w_fire     = r_s2_valid & i_ready_out;
    assign w_count_en = w_fire & r_s2_flag & (r_s2_epoch == r_epoch);
    assign o_ready_in = ~w_stall;

    // Stage 1: per-lane depth, bounds and stencil compares on the incoming beat.
    always_comb begin
        w_dpass = '0;
        w_spass = '0;
        w_sref  = '0;
        w_smask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_sref[i]  = i_dcrs.stencil_ref[i_face[i]][STENCIL_BITS-1:0];
            w_smask[i] = i_dcrs.stencil_mask[i_face[i]][STENCIL_BITS-1:0];
            w_dpass[i] = f_cmp(i_dcrs.depth_func, CW'(i_depth_ref[i]), CW'(i_depth_val[i]))
                       & (~i_bounds_en | ((i_depth_val[i] >= i_bounds_min) & (i_depth_val[i] <= i_bounds_max)));
            w_spass[i] = f_cmp(i_dcrs.stencil_func[i_face[i]], CW'(w_sref[i] & w_smask[i]),
                               CW'(i_stencil_val[i] & w_smask[i]));
        end
    end

    // Stage 2: stencil op selection and write-back values; dead lanes pass stored data through.
    always_comb begin
        w_op    = '0;
        w_wm    = '0;
        w_sres  = '0;
        w_sten  = '0;
        w_depth = '0;
        w_pass  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_op[i]    = r_s1_spass[i] ? (r_s1_dpass[i] ? i_dcrs.stencil_zpass[r_s1_face[i]]
                                                        : i_dcrs.stencil_zfail[r_s1_face[i]])
                                       : i_dcrs.stencil_fail[r_s1_face[i]];
            w_wm[i]    = i_dcrs.stencil_writemask[r_s1_face[i]][STENCIL_BITS-1:0];
            w_sres[i]  = f_op(w_op[i], r_s1_sval[i], i_dcrs.stencil_ref[r_s1_face[i]][STENCIL_BITS-1:0]);
            w_sten[i]  = r_s1_mask[i] ? ((w_sres[i] & w_wm[i]) | (r_s1_sval[i] & ~w_wm[i])) : r_s1_sval[i];
            w_depth[i] = (r_s1_mask[i] & r_s1_dpass[i] & i_dcrs.depth_writemask) ? r_s1_dref[i] : r_s1_dval[i];
            w_pass[i]  = r_s1_mask[i] & r_s1_spass[i] & r_s1_dpass[i];
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_pop = w_pop + PW'(r_s2_pass[i]);
    end

    assign w_sum = {1'b0, r_count} + (COUNT_BITS+1)'(w_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_flag  <= 1'b0;
            r_s1_epoch <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_flag  <= 1'b0;
            r_s2_epoch <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= i_valid_in;
            r_s1_flag  <= i_valid_in & r_active;
            r_s1_epoch <= r_epoch;
            r_s2_valid <= r_s1_valid;
            r_s2_flag  <= r_s1_flag;
            r_s2_epoch <= r_s1_epoch;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!w_stall) begin
            r_s1_tag   <= i_tag_in;
            r_s1_mask  <= i_mask_in;
            r_s1_face  <= i_face;
            r_s1_dpass <= w_dpass;
            r_s1_spass <= w_spass;
            r_s1_dref  <= i_depth_ref;
            r_s1_dval  <= i_depth_val;
            r_s1_sval  <= i_stencil_val;
            r_s2_tag   <= r_s1_tag;
            r_s2_pass  <= w_pass;
            r_s2_depth <= w_depth;
            r_s2_sten  <= w_sten;
        end
    end

    // A begin pulse wins over both end and a same-cycle count update.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_active <= 1'b0;
            r_epoch  <= 1'b0;
            r_count  <= '0;
        end else if (i_query_begin) begin
            r_active <= 1'b1;
            r_epoch  <= ~r_epoch;
            r_count  <= '0;
        end else begin
            if (i_query_end)
                r_active <= 1'b0;
            if (w_count_en)
                r_count <= w_sum[COUNT_BITS] ? '1 : w_sum[COUNT_BITS-1:0];
        end
    end

    assign o_valid_out    = r_s2_valid;
    assign o_tag_out      = r_s2_tag;
    assign o_depth_out    = r_s2_depth;
    assign o_stencil_out  = r_s2_sten;
    assign o_pass_out     = r_s2_pass;
    assign o_query_active = r_active;
    assign o_query_count  = r_count;
    assign o_query_done   = ~r_active
                          & ~(r_s1_valid & r_s1_flag & (r_s1_epoch == r_epoch))
                          & ~(r_s2_valid & r_s2_flag & (r_s2_epoch == r_epoch));

endmodule

// File: tb/tb_vx_om_ds_occlusion.sv
// tb_vx_om_ds_occlusion: directed checks of compares, masking, backpressure and the occlusion query.
module tb_vx_om_ds_occlusion;
    import vx_om_ds_pkg::*;

    localparam int NL = 4;
    localparam int DB = 24;
    localparam int SB = 8;
    localparam int TW = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    om_dcrs_t                dcrs;
    logic                    bounds_en;
    logic [DB-1:0]           bounds_min, bounds_max;
    logic                    valid_in, ready_in, valid_out, ready_out;
    logic [TW-1:0]           tag_in, tag_out;
    logic [NL-1:0]           mask_in, face, pass_out;
    logic [NL-1:0][DB-1:0]   depth_ref, depth_val, depth_out;
    logic [NL-1:0][SB-1:0]   stencil_val, stencil_out;
    logic                    q_begin, q_end, q_active, q_done;
    logic [31:0]             q_count;
    logic                    ready_in_s, valid_out_s, q_active_s, q_done_s;
    logic [TW-1:0]           tag_out_s;
    logic [NL-1:0]           pass_out_s;
    logic [NL-1:0][DB-1:0]   depth_out_s;
    logic [NL-1:0][SB-1:0]   stencil_out_s;
    logic [3:0]              q_count_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_om_ds_occlusion #(.NUM_LANES(NL), .TAG_WIDTH(TW), .DEPTH_BITS(DB), .STENCIL_BITS(SB), .COUNT_BITS(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_dcrs(dcrs), .i_bounds_en(bounds_en),
        .i_bounds_min(bounds_min), .i_bounds_max(bounds_max),
        .i_valid_in(valid_in), .o_ready_in(ready_in), .i_tag_in(tag_in), .i_mask_in(mask_in),
        .i_face(face), .i_depth_ref(depth_ref), .i_depth_val(depth_val), .i_stencil_val(stencil_val),
        .o_valid_out(valid_out), .i_ready_out(ready_out), .o_tag_out(tag_out),
        .o_depth_out(depth_out), .o_stencil_out(stencil_out), .o_pass_out(pass_out),
        .i_query_begin(q_begin), .i_query_end(q_end), .o_query_active(q_active),
        .o_query_done(q_done), .o_query_count(q_count)
    );

    vx_om_ds_occlusion #(.NUM_LANES(NL), .TAG_WIDTH(TW), .DEPTH_BITS(DB), .STENCIL_BITS(SB), .COUNT_BITS(4)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_dcrs(dcrs), .i_bounds_en(bounds_en),
        .i_bounds_min(bounds_min), .i_bounds_max(bounds_max),
        .i_valid_in(valid_in), .o_ready_in(ready_in_s), .i_tag_in(tag_in), .i_mask_in(mask_in),
        .i_face(face), .i_depth_ref(depth_ref), .i_depth_val(depth_val), .i_stencil_val(stencil_val),
        .o_valid_out(valid_out_s), .i_ready_out(ready_out), .o_tag_out(tag_out_s),
        .o_depth_out(depth_out_s), .o_stencil_out(stencil_out_s), .o_pass_out(pass_out_s),
        .i_query_begin(q_begin), .i_query_end(q_end), .o_query_active(q_active_s),
        .o_query_done(q_done_s), .o_query_count(q_count_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int next_tag, n_obs, k;
        logic [TW-1:0] obs [8];
        rst = 1'b1;
        dcrs = '0;
        dcrs.depth_func = OM_CMP_LESS;
        dcrs.depth_writemask = 1'b1;
        dcrs.stencil_func[0] = OM_CMP_ALWAYS;
        dcrs.stencil_zpass[0] = OM_OP_INCR;
        dcrs.stencil_zfail[0] = OM_OP_ZERO;
        dcrs.stencil_fail[0] = OM_OP_KEEP;
        dcrs.stencil_mask[0] = 8'hFF;
        dcrs.stencil_writemask[0] = 8'hFF;
        dcrs.stencil_func[1] = OM_CMP_ALWAYS;
        dcrs.stencil_zpass[1] = OM_OP_DECR;
        dcrs.stencil_mask[1] = 8'hFF;
        dcrs.stencil_writemask[1] = 8'hFF;
        bounds_en = 1'b0;
        bounds_min = '0;
        bounds_max = '0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        tag_in = '0;
        mask_in = 4'hF;
        face = 4'h0;
        depth_ref = {4{24'h100}};
        depth_val = {4{24'h200}};
        stencil_val = {4{8'd5}};
        q_begin = 1'b0;
        q_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_active", q_active, 0);
        check("rst_count", q_count, 0);
        check("rst_done", q_done, 1);
        rst = 1'b0;
        tick();
        check("rst_ready_in", ready_in, 1);

        // Basic: LESS passes, INCR stencil
        valid_in = 1'b1;
        tag_in = 2'd1;
        tick();
        valid_in = 1'b0;
        check("lat_n1_valid", valid_out, 0);
        tick();
        check("basic_valid", valid_out, 1);
        check("basic_tag", tag_out, 1);
        check("basic_pass", pass_out, 4'hF);
        check("basic_depth", depth_out, {4{24'h100}});
        check("basic_stencil", stencil_out, {4{8'd6}});

        // Masking, bounds and back-face op
        mask_in = 4'b0101;
        face = 4'b0100;
        bounds_en = 1'b1;
        bounds_min = 24'h150;
        bounds_max = 24'h300;
        depth_val = {24'h400, 24'h200, 24'h200, 24'h100};
        valid_in = 1'b1;
        tag_in = 2'd2;
        tick();
        valid_in = 1'b0;
        tick();
        check("mb_valid", valid_out, 1);
        check("mb_pass", pass_out, 4'b0100);
        check("mb_depth", depth_out, {24'h400, 24'h100, 24'h200, 24'h100});
        check("mb_stencil", stencil_out, {8'd5, 8'd4, 8'd5, 8'd0});
        tick();
        mask_in = 4'hF;
        face = 4'h0;
        bounds_en = 1'b0;
        depth_val = {4{24'h200}};

        // Backpressure: ready_out low for 5 cycles while 3 beats are offered
        next_tag = 1;
        n_obs = 0;
        for (int c = 0; c < 20; c++) begin
            ready_out = (c < 5) ? 1'b0 : 1'b1;
            valid_in = (next_tag <= 3);
            tag_in = TW'(next_tag);
            #1;
            if (c == 3) begin
                check("bp_ready_in_low", ready_in, 0);
                check("bp_valid_held", valid_out, 1);
                check("bp_tag_held", tag_out, 1);
            end
            if (valid_out && ready_out) begin
                if (n_obs < 8) obs[n_obs] = tag_out;
                n_obs++;
            end
            if (valid_in && ready_in) next_tag++;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        check("bp_count", n_obs, 3);
        check("bp_tag0", obs[0], 1);
        check("bp_tag1", obs[1], 2);
        check("bp_tag2", obs[2], 3);

        // Occlusion count: 10 beats with 3 live passing lanes
        mask_in = 4'b0111;
        q_begin = 1'b1;
        tick();
        q_begin = 1'b0;
        check("oc_active", q_active, 1);
        check("oc_done_low", q_done, 0);
        valid_in = 1'b1;
        repeat (10) tick();
        valid_in = 1'b0;
        q_end = 1'b1;
        tick();
        q_end = 1'b0;
        check("oc_inactive", q_active, 0);
        check("oc_done_inflight", q_done, 0);
        check("oc_count_partial", q_count, 27);
        tick();
        check("oc_done", q_done, 1);
        check("oc_count", q_count, 30);

        // Restart with stale beats in flight
        mask_in = 4'hF;
        q_begin = 1'b1;
        tick();
        q_begin = 1'b0;
        valid_in = 1'b1;
        repeat (2) tick();
        valid_in = 1'b0;
        q_begin = 1'b1;
        tick();
        q_begin = 1'b0;
        check("rs_clear_wins", q_count, 0);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("rs_stale_ignored", q_count, 0);
        q_end = 1'b1;
        tick();
        q_end = 1'b0;
        check("rs_done_inflight", q_done, 0);
        tick();
        check("rs_count", q_count, 4);
        check("rs_done", q_done, 1);

        // Saturation on the 4-bit counter instance
        q_begin = 1'b1;
        tick();
        q_begin = 1'b0;
        valid_in = 1'b1;
        repeat (5) tick();
        valid_in = 1'b0;
        q_end = 1'b1;
        tick();
        q_end = 1'b0;
        k = 0;
        while (!q_done && k < 10) begin
            tick();
            k++;
        end
        check("sat_done", q_done, 1);
        check("sat_count_wide", q_count, 20);
        check("sat_count_4b", q_count_s, 15);

        // Reset mid-stream with an active query and 2 beats in flight
        q_begin = 1'b1;
        tick();
        q_begin = 1'b0;
        valid_in = 1'b1;
        repeat (3) tick();
        valid_in = 1'b0;
        check("mr_pre_count", q_count, 4);
        check("mr_pre_valid", valid_out, 1);
        check("mr_pre_active", q_active, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid_out", valid_out, 0);
        check("mr_count", q_count, 0);
        check("mr_done", q_done, 1);
        check("mr_active", q_active, 0);
        check("mr_count_4b", q_count_s, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("mr_post_valid", valid_out, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vx_om_ds_occlusion.md
# VX_om_ds_occlusion

Parametrised depth/stencil test unit with per-lane fragment mask, depth-bounds test and an occlusion-query counter. It sits in the OM pipeline between the depth/stencil buffer read and write-back, replacing the fixed-width depth/stencil stage. Each accepted beat is tested, and stencil ops and write masks are applied. Passing fragments of beats flagged to the active query are counted.

## Interface
Parameters:
- INSTANCE_ID, "", debug name (unused in logic)
- NUM_LANES, 4, fragments per beat
- TAG_WIDTH, 1, opaque tag carried with each beat
- DEPTH_BITS, 24, depth value width
- STENCIL_BITS, 8, stencil value width
- COUNT_BITS, 32, occlusion counter width

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- dcrs  in  om_dcrs_t  depth/stencil func, ref, mask, ops, writemasks (front/back indexed by face)
- bounds_en  in  1  enable depth-bounds test
- bounds_min, bounds_max  in  DEPTH_BITS each  inclusive bounds on stored depth
- valid_in / ready_in  in / out  1  input handshake
- tag_in  in  TAG_WIDTH
- mask_in  in  NUM_LANES  lane live mask
- face  in  NUM_LANES  0 = front, 1 = back
- depth_ref, depth_val  in  NUM_LANES×DEPTH_BITS  incoming fragment depth / stored depth
- stencil_val  in  NUM_LANES×STENCIL_BITS  stored stencil
- valid_out / ready_out  out / in  1  output handshake
- tag_out  out  TAG_WIDTH
- depth_out, stencil_out  out  per-lane write-back values
- pass_out  out  NUM_LANES  lane passed all tests
- query_begin, query_end  in  1  single-cycle pulses
- query_active  out  1
- query_done  out  1  query closed and no flagged beats in flight
- query_count  out  COUNT_BITS  passing-fragment count

## Operation
- Stage 1 (registered): per-lane compares.
  - Depth compare uses dcrs.depth_func(depth_ref, depth_val) with the standard OM compare encoding.
  - Stencil compare is func(ref&mask, val&mask), using the face-selected dcrs fields.
  - Depth-bounds result is bpass = ~bounds_en | (bounds_min ≤ depth_val ≤ bounds_max). Comparisons are unsigned.
  - dpass = depth compare & bpass.
- Stage 2 (registered): stencil op selection.
  - Op = spass ? (dpass ? zpass : zfail) : fail.
  - stencil_out is applied bitwise through the face writemask.
  - depth_out = (dpass & depth_writemask) ? depth_ref : depth_val.
  - pass_out = spass & dpass.
- Masked lanes (mask_in = 0) give pass_out = 0, depth_out = depth_val and stencil_out = stencil_val, regardless of the compare results.
- Query state:
  - active flag plus a 1-bit epoch.
  - query_begin sets active, toggles epoch and clears query_count, all in the next cycle.
  - query_end clears active.
  - Simultaneous begin and end: begin wins, end is ignored.
  - query_begin while already active restarts the query.
- Beat flagging:
  - A beat accepted (valid_in & ready_in) while active = 1 in that cycle is flagged and stamped with the current epoch.
  - The cycle carrying query_begin itself sees active as it was before the pulse.
- Counting:
  - On an output fire (valid_out & ready_out) of a flagged beat whose epoch equals the current epoch, query_count += popcount(pass_out).
  - The add saturates at 2^COUNT_BITS-1.
  - Stale-epoch beats are never counted.
- query_done = ~active & no pipeline stage holds a valid, flagged, current-epoch beat.

## Timing
- Latency is 2 cycles: a beat accepted at cycle N appears on valid_out at N+2 when not stalled.
- stall = valid_out & ~ready_out. ready_in = ~stall. All pipeline stages freeze on stall; bubbles are not collapsed.
- Throughput is 1 beat/cycle when ready_out = 1.
- Reset values (asynchronous):
  - valid_out = 0; internal stage valids = 0.
  - query_active = 0, epoch = 0, query_count = 0.
  - query_done = 1.
  - Data outputs are don't-care while valid_out = 0.
- Reset mid-operation: in-flight beats are discarded, and the query is aborted with count 0.
- query_count is updated one cycle after the firing output beat. query_done reflects the post-update state in the same cycle the count settles.
- Begin and fire in the same cycle: the clear takes precedence, and the firing beat (old epoch) is not added.

## Test plan
- Basic pass/fail:
  - Stimulus: depth_func LESS, ref = 0x100, val = 0x200 on all 4 lanes, mask_in = 0xF, stencil ALWAYS, zpass = INCR, writemask 0xFF, stencil_val = 5.
  - Required at N+2: pass_out = 0xF, depth_out = 0x100, stencil_out = 6.
- Masking and bounds:
  - Stimulus: mask_in = 0b0101, bounds_en = 1, bounds [0x150, 0x300], val = {0x100, 0x200, 0x200, 0x400}.
  - Required: pass_out = 0b0100; lane 0 gets zfail op; masked lanes return stored values unchanged.
- Backpressure:
  - Stimulus: hold ready_out = 0 for 5 cycles with 3 beats issued.
  - Required: ready_in drops once valid_out is up; no beat is lost or duplicated; tags emerge in order 1, 2, 3.
- Occlusion count:
  - Stimulus: begin, then 10 beats with 3 passing lanes each, then end.
  - Required: query_count = 30, and query_done rises only after the last beat fires.
- Restart with stale beats:
  - Stimulus: begin, 2 beats in flight, begin again before they exit, 1 new beat with 4 passing lanes, end.
  - Required: count = 4.
- Saturation:
  - Stimulus: COUNT_BITS = 4; 5 beats with 4 passing lanes each.
  - Required: query_count = 15.
- Reset mid-stream: assert reset with 2 beats in flight and active = 1. Required: valid_out = 0 immediately, query_count = 0, query_done = 1.
